// File: rtl/flash_nav_pkg.sv
// Shared opcodes, state encodings and frame helpers for the SPI-flash command sequencer.
package flash_nav_pkg;

    localparam logic [7:0] OP_RDP  = 8'hAB;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_RDSR = 8'h05;

    typedef enum logic [2:0] {
        StIdle,
        StWakeCmd,
        StWakeWait,
        StWren,
        StProg,
        StPoll,
        StRead,
        StDone
    } state_e;

    // Position inside one CS-low transaction.
    typedef enum logic [1:0] {
        PhSend,
        PhWait,
        PhHold,
        PhGap
    } phase_e;

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [2:0] last_idx(state_e s);
        case (s)
            StRead, StProg: return 3'd7;
            StPoll:         return 3'd1;
            default:        return 3'd0;
        endcase
    endfunction

    // Every transaction is a prefix of an 8-byte frame; dummy bytes are zero.
    function automatic logic [7:0] frame_byte(state_e s, logic [2:0] idx, logic [23:0] raddr,
                                              logic [23:0] waddr, logic [31:0] wdata);
        logic [63:0] frame;
        logic [63:0] shifted;
        case (s)
            StWakeCmd: frame = {OP_RDP, 56'h0};
            StWren:    frame = {OP_WREN, 56'h0};
            StProg:    frame = {OP_PP, waddr, wdata};
            StPoll:    frame = {OP_RDSR, 56'h0};
            StRead:    frame = {OP_READ, raddr, 32'h0};
            default:   frame = '0;
        endcase
        shifted = frame >> {3'd7 - idx, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/flash_navigator_shifter.sv
// Full-duplex 8-bit SPI mode-0 shifter: MSB first, SCK idles low, MISO sampled on SCK rise.
module spi_byte_shifter #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic [7:0] i_tx_byte,
    input  logic       i_miso,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_done,
    output logic [7:0] o_rx_byte
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic            r_busy;
    logic [DivW-1:0] r_div;
    logic [2:0]      r_bit;
    logic            r_sck;
    logic [7:0]      r_sh;
    logic [7:0]      r_rx;
    logic            r_done;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_busy <= 1'b0;
            r_div  <= '0;
            r_bit  <= '0;
            r_sck  <= 1'b0;
            r_sh   <= '0;
            r_rx   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_start) begin
                    r_busy <= 1'b1;
                    r_sh   <= i_tx_byte;
                    r_div  <= '0;
                    r_bit  <= '0;
                end
            end else if (r_div == DivLast) begin
                r_div <= '0;
                if (!r_sck) begin
                    r_sck <= 1'b1;
                    r_rx  <= {r_rx[6:0], i_miso};
                end else begin
                    // MOSI advances on the falling edge, a full half-period ahead of the next rise.
                    r_sck <= 1'b0;
                    r_sh  <= {r_sh[6:0], 1'b0};
                    if (r_bit == 3'd7) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_bit <= r_bit + 3'd1;
                    end
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_sck     = r_sck;
    assign o_mosi    = r_sh[7];
    assign o_done    = r_done;
    assign o_rx_byte = r_rx;

endmodule

// File: rtl/flash_navigator.sv
// SPI-flash command sequencer: wake-up, 32-bit read, WREN + page program + status polling.
module flash_navigator #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned WAKE_CYCLES = 256,
    parameter int unsigned CS_IDLE     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flash_enable,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [23:0] readAddress,
    input  logic [23:0] writeAddress,
    input  logic [31:0] dataToWrite,
    input  logic        flashMiso,
    output logic        flashClk,
    output logic        flashMosi,
    output logic        flashCs,
    output logic        flash_ready,
    output logic [31:0] data_out
);

    import flash_nav_pkg::*;

    localparam int unsigned MaxCnt = max_u(max_u(WAKE_CYCLES, CS_IDLE), max_u(CLK_DIV, 2));
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    localparam logic [CntW-1:0] HoldLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(CS_IDLE - 1);
    localparam logic [CntW-1:0] WakeLast = CntW'(WAKE_CYCLES - 1);
    localparam logic [CntW-1:0] DoneLast = CntW'(1);

    state_e          r_state;
    phase_e          r_ph;
    logic [2:0]      r_idx;
    logic [CntW-1:0] r_cnt;
    logic            r_init;
    logic            r_cs;
    logic            r_ready;
    logic            r_start;
    logic [7:0]      r_tx;
    logic [23:0]     r_raddr;
    logic [23:0]     r_waddr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rd_word;
    logic            r_wip;
    logic [31:0]     r_data_out;

    logic            w_done;
    logic [7:0]      w_rx_byte;
    logic [7:0]      w_tx_byte;
    logic [2:0]      w_last;

    assign w_tx_byte = frame_byte(r_state, r_idx, r_raddr, r_waddr, r_wdata);
    assign w_last    = last_idx(r_state);

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_start   (r_start),
        .i_tx_byte (r_tx),
        .i_miso    (flashMiso),
        .o_sck     (flashClk),
        .o_mosi    (flashMosi),
        .o_done    (w_done),
        .o_rx_byte (w_rx_byte)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_ph       <= PhSend;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_init     <= 1'b0;
            r_cs       <= 1'b1;
            r_ready    <= 1'b1;
            r_start    <= 1'b0;
            r_tx       <= '0;
            r_raddr    <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_rd_word  <= '0;
            r_wip      <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (flash_enable && (read_enable || write_enable)) begin
                        r_raddr <= readAddress;
                        r_waddr <= writeAddress;
                        r_wdata <= dataToWrite;
                        r_ready <= 1'b0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_ph    <= PhSend;
                        // The very first request only releases the flash from deep power-down.
                        if (!r_init) begin
                            r_state <= StWakeCmd;
                        end else if (write_enable) begin
                            r_state <= StWren;
                        end else begin
                            r_state <= StRead;
                        end
                    end
                end

                StWakeWait: begin
                    if (r_cnt == WakeLast) begin
                        r_init  <= 1'b1;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Two-cycle deaf window so a late-withdrawing requester cannot retrigger.
                StDone: begin
                    if (r_cnt == DoneLast) begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                StWakeCmd, StWren, StProg, StPoll, StRead: begin
                    unique case (r_ph)
                        PhSend: begin
                            r_cs    <= 1'b0;
                            r_start <= 1'b1;
                            r_tx    <= w_tx_byte;
                            r_ph    <= PhWait;
                        end
                        PhWait: begin
                            if (w_done) begin
                                r_rd_word <= {r_rd_word[23:0], w_rx_byte};
                                r_wip     <= w_rx_byte[0];
                                if (r_idx == w_last) begin
                                    r_cnt <= '0;
                                    r_ph  <= PhHold;
                                end else begin
                                    r_idx <= r_idx + 3'd1;
                                    r_ph  <= PhSend;
                                end
                            end
                        end
                        PhHold: begin
                            if (r_cnt == HoldLast) begin
                                r_cs  <= 1'b1;
                                r_cnt <= '0;
                                r_ph  <= PhGap;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        PhGap: begin
                            if (r_cnt == GapLast) begin
                                r_cnt <= '0;
                                r_idx <= '0;
                                r_ph  <= PhSend;
                                case (r_state)
                                    StWakeCmd: r_state <= StWakeWait;
                                    StWren:    r_state <= StProg;
                                    StProg:    r_state <= StPoll;
                                    StPoll: begin
                                        if (!r_wip) begin
                                            r_ready <= 1'b1;
                                            r_state <= StDone;
                                        end
                                    end
                                    StRead: begin
                                        r_data_out <= r_rd_word;
                                        r_ready    <= 1'b1;
                                        r_state    <= StDone;
                                    end
                                    default: r_state <= StIdle;
                                endcase
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        default: r_ph <= PhSend;
                    endcase
                end

                default: r_state <= StIdle;
            endcase
        end
    end

    assign flashCs     = r_cs;
    assign flash_ready = r_ready;
    assign data_out    = r_data_out;

endmodule

// File: tb/tb_flash_navigator.sv
// Bench for flash_navigator: behavioural 25-series flash model, vector table, random ops, resets.
module tb_flash_navigator;

    localparam int unsigned CLK_DIV     = 2;
    localparam int unsigned WAKE_CYCLES = 40;
    localparam int unsigned CS_IDLE     = 8;
    localparam int          WAIT_BUDGET = 3000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flash_enable;
    logic        read_enable;
    logic        write_enable;
    logic [23:0] readAddress;
    logic [23:0] writeAddress;
    logic [31:0] dataToWrite;
    logic        flash_miso = 1'b0;
    logic        flashClk;
    logic        flashMosi;
    logic        flashCs;
    logic        flash_ready;
    logic [31:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;

    flash_navigator #(
        .CLK_DIV     (CLK_DIV),
        .WAKE_CYCLES (WAKE_CYCLES),
        .CS_IDLE     (CS_IDLE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flash_enable (flash_enable),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .readAddress  (readAddress),
        .writeAddress (writeAddress),
        .dataToWrite  (dataToWrite),
        .flashMiso    (flash_miso),
        .flashClk     (flashClk),
        .flashMosi    (flashMosi),
        .flashCs      (flashCs),
        .flash_ready  (flash_ready),
        .data_out     (data_out)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural flash model ----------------
    logic [7:0] mem [logic [23:0]];
    logic [7:0] cur [$];
    int         nbits;
    logic [7:0] shreg;
    bit         in_txn = 1'b0;
    bit         wel = 1'b0;
    int         busy_left = 0;
    int         busy_cfg = 0;
    logic       m_cs = 1'b1;
    logic       m_clk = 1'b0;
    logic [7:0] log_bytes [$];
    int         log_len [$];
    int         log_bits [$];

    function automatic logic [7:0] mem_rd(logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic out_bit();
        logic [23:0] a;
        logic [7:0]  b;
        if (cur.size() == 0) return 1'b0;
        if (cur[0] == 8'h03 && nbits >= 32) begin
            a = {cur[1], cur[2], cur[3]};
            b = mem_rd(a + 24'((nbits - 32) / 8));
            return b[7 - (nbits % 8)];
        end
        if (cur[0] == 8'h05 && nbits >= 8) begin
            b = {6'd0, wel, busy_left != 0};
            return b[7 - (nbits % 8)];
        end
        return 1'b0;
    endfunction

    always @(flashCs or flashClk) begin
        if (flashClk !== m_clk) begin
            if (flashClk === 1'b1 && flashCs === 1'b0 && in_txn) begin
                shreg = {shreg[6:0], flashMosi};
                nbits++;
                if (nbits % 8 == 0) cur.push_back(shreg);
            end else if (flashClk === 1'b0 && flashCs === 1'b0 && in_txn) begin
                flash_miso = out_bit();
            end
            m_clk = flashClk;
        end
        if (flashCs !== m_cs) begin
            if (flashCs === 1'b0) begin
                in_txn = 1'b1;
                cur.delete();
                nbits = 0;
                flash_miso = 1'b0;
            end else if (flashCs === 1'b1 && in_txn) begin
                in_txn = 1'b0;
                log_len.push_back(cur.size());
                log_bits.push_back(nbits);
                foreach (cur[i]) log_bytes.push_back(cur[i]);
                if (cur.size() > 0) begin
                    if (cur[0] == 8'h06 && nbits == 8) wel = 1'b1;
                    // Unerased NOR: programming can only clear bits; address wraps inside the page.
                    if (cur[0] == 8'h02 && nbits == 64 && wel) begin
                        for (int k = 0; k < 4; k++) begin
                            logic [23:0] pa;
                            pa = {cur[1], cur[2], cur[3] + 8'(k)};
                            mem[pa] = mem_rd(pa) & cur[4 + k];
                        end
                        wel = 1'b0;
                        busy_left = busy_cfg;
                    end
                    if (cur[0] == 8'h05 && busy_left > 0) busy_left--;
                end
            end
            m_cs = flashCs;
        end
    end

    // MOSI must hold while SCK is high and be set up before each rising edge.
    int   n_viol = 0;
    logic mon_mosi = 1'b0;
    always @(negedge clk) begin
        if (reset_n === 1'b1 && flashCs === 1'b0 && flashClk === 1'b1 && flashMosi !== mon_mosi)
            n_viol++;
        mon_mosi = flashMosi;
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: bench still running after 100000 cycles, required to finish");
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input logic lvl, input string name);
        int i;
        for (i = 0; i < WAIT_BUDGET; i++) begin
            @(negedge clk);
            if (flash_ready === lvl) break;
        end
        if (i == WAIT_BUDGET) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: flash_ready never reached %0b within %0d cycles", name, lvl,
                     WAIT_BUDGET);
        end
    endtask

    task automatic clear_log();
        log_bytes.delete();
        log_len.delete();
        log_bits.delete();
    endtask

    task automatic drop_req();
        flash_enable = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        readAddress  = 24'($urandom);
        writeAddress = 24'($urandom);
        dataToWrite  = $urandom;
    endtask

    task automatic compare_log(input string tag, input logic [7:0] eb[$], input int el[$]);
        int off;
        logic [63:0] act;
        logic [63:0] exp;
        check({tag, "/txn_count"}, log_len.size(), el.size());
        off = 0;
        for (int t = 0; t < el.size() && t < log_len.size(); t++) begin
            check($sformatf("%s/txn%0d_bits", tag, t), log_bits[t], 8 * el[t]);
            act = '0;
            exp = '0;
            for (int b = 0; b < el[t]; b++) begin
                exp = {exp[55:0], eb[off + b]};
                act = {act[55:0], (off + b < log_bytes.size()) ? log_bytes[off + b] : 8'hxx};
            end
            check($sformatf("%s/txn%0d_bytes", tag, t), act, exp);
            off += el[t];
        end
    endtask

    // One request on an already-woken flash; expected bus traffic derived from the command rules.
    task automatic do_op(input bit re, input bit we, input logic [23:0] ra, input logic [23:0] wa,
                         input logic [31:0] wd, input int busy, input bit hold,
                         input logic [31:0] exp_data, input string tag);
        logic [7:0] eb[$];
        int el[$];
        int n_after;
        if (we) begin
            el.push_back(1);
            eb.push_back(8'h06);
            el.push_back(8);
            eb.push_back(8'h02);
            eb.push_back(wa[23:16]); eb.push_back(wa[15:8]); eb.push_back(wa[7:0]);
            eb.push_back(wd[31:24]); eb.push_back(wd[23:16]);
            eb.push_back(wd[15:8]);  eb.push_back(wd[7:0]);
            for (int p = 0; p <= busy; p++) begin
                el.push_back(2);
                eb.push_back(8'h05);
                eb.push_back(8'h00);
            end
        end else begin
            el.push_back(8);
            eb.push_back(8'h03);
            eb.push_back(ra[23:16]); eb.push_back(ra[15:8]); eb.push_back(ra[7:0]);
            for (int p = 0; p < 4; p++) eb.push_back(8'h00);
        end
        clear_log();
        busy_cfg = busy;
        @(negedge clk);
        flash_enable = 1'b1;
        read_enable  = re;
        write_enable = we;
        readAddress  = ra;
        writeAddress = wa;
        dataToWrite  = wd;
        @(posedge clk);
        #1;
        check({tag, "/ready_fall"}, flash_ready, 1'b0);
        if (!hold) drop_req();
        wait_ready(1'b1, {tag, "/ready_rise"});
        check({tag, "/data_out"}, data_out, exp_data);
        check({tag, "/txn_at_rise"}, log_len.size(), el.size());
        @(posedge clk);
        #1;
        drop_req();
        repeat (CS_IDLE + 6) @(negedge clk);
        n_after = log_len.size();
        check({tag, "/no_retrigger_ready"}, {flash_ready, flashCs}, 2'b11);
        compare_log(tag, eb, el);
        check({tag, "/no_retrigger_txn"}, n_after, el.size());
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        bit          re;
        bit          we;
        logic [23:0] raddr;
        logic [23:0] waddr;
        logic [31:0] wdata;
        int          busy;
        bit          hold;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0]  eb[$];
        int          el[$];
        logic [31:0] exp_dout;
        bit          re, we, hold;
        logic [23:0] ra, wa;
        logic [31:0] wd;

        vecs[0] = '{1'b1, 1'b0, 24'h000010, 24'h000000, 32'h0,          0, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 24'h000000, 24'h500004, 32'h12345678,   2, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 24'h500004, 24'h000000, 32'h0,          0, 1'b0, 32'h12345678};
        vecs[3] = '{1'b1, 1'b1, 24'h000010, 24'h000020, 32'hA5A50F0F,   0, 1'b1, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 24'h000020, 24'h000000, 32'h0,          0, 1'b1, 32'hA5A50F0F};
        vecs[5] = '{1'b1, 1'b0, 24'h0000FE, 24'h000000, 32'h0,          1, 1'b0, 32'hA4A55B5A};

        mem[24'h000010] = 8'hDE; mem[24'h000011] = 8'hAD;
        mem[24'h000012] = 8'hBE; mem[24'h000013] = 8'hEF;
        for (int k = 0; k < 4; k++) begin
            mem[24'h500004 + 24'(k)] = 8'hFF;
            mem[24'h000020 + 24'(k)] = 8'hFF;
        end

        reset_n = 1'b0;
        drop_req();
        repeat (3) @(posedge clk);
        #1;
        check("reset/ready", flash_ready, 1'b1);
        check("reset/cs", flashCs, 1'b1);
        check("reset/sck", flashClk, 1'b0);
        check("reset/mosi", flashMosi, 1'b0);
        check("reset/data_out", data_out, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Wake-up on the first request, then the held request performs the real read.
        clear_log();
        @(negedge clk);
        flash_enable = 1'b1;
        read_enable  = 1'b1;
        readAddress  = 24'h000010;
        @(posedge clk);
        #1;
        check("wake/ready_fall", flash_ready, 1'b0);
        wait_ready(1'b1, "wake/ready_rise");
        check("wake/data_out", data_out, 32'h0);
        eb.push_back(8'hAB);
        el.push_back(1);
        compare_log("wake", eb, el);
        wait_ready(1'b0, "held/ready_fall");
        wait_ready(1'b1, "held/ready_rise");
        check("held/data_out", data_out, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        drop_req();
        repeat (CS_IDLE + 6) @(negedge clk);
        eb.push_back(8'h03);
        eb.push_back(8'h00); eb.push_back(8'h00); eb.push_back(8'h10);
        for (int p = 0; p < 4; p++) eb.push_back(8'h00);
        el.push_back(8);
        compare_log("held", eb, el);
        check("held/idle", {flash_ready, flashCs}, 2'b11);

        for (int v = 0; v < 6; v++) begin
            do_op(vecs[v].re, vecs[v].we, vecs[v].raddr, vecs[v].waddr, vecs[v].wdata,
                  vecs[v].busy, vecs[v].hold, vecs[v].exp_data, $sformatf("vec%0d", v));
        end
        exp_dout = vecs[5].exp_data;

        for (int r = 0; r < 16; r++) begin
            re   = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            if (!re && !we) re = 1'b1;
            ra = 24'h300000 | {18'd0, 4'($urandom_range(0, 15)), 2'b00};
            wa = 24'h300000 | {18'd0, 4'($urandom_range(0, 15)), 2'b00};
            wd = $urandom;
            if (!we) exp_dout = {mem_rd(ra), mem_rd(ra + 24'd1), mem_rd(ra + 24'd2),
                                 mem_rd(ra + 24'd3)};
            do_op(re, we, ra, wa, wd, int'($urandom_range(0, 3)), hold, exp_dout,
                  $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a page program, then the flash must be woken again.
        clear_log();
        busy_cfg = 0;
        @(negedge clk);
        flash_enable = 1'b1;
        write_enable = 1'b1;
        writeAddress = 24'h600000;
        dataToWrite  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        drop_req();
        repeat (100) @(negedge clk);
        check("midreset/cs_low_before", flashCs, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset/cs", flashCs, 1'b1);
        check("midreset/sck", flashClk, 1'b0);
        check("midreset/ready", flash_ready, 1'b1);
        check("midreset/data_out", data_out, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (CS_IDLE) @(negedge clk);
        clear_log();
        eb.delete();
        el.delete();
        eb.push_back(8'hAB);
        el.push_back(1);
        flash_enable = 1'b1;
        read_enable  = 1'b1;
        readAddress  = 24'h000010;
        @(posedge clk);
        #1;
        check("rewake/ready_fall", flash_ready, 1'b0);
        wait_ready(1'b1, "rewake/ready_rise");
        check("rewake/data_out", data_out, 32'h0);
        @(posedge clk);
        #1;
        drop_req();
        repeat (CS_IDLE + 6) @(negedge clk);
        compare_log("rewake", eb, el);
        check("rewake/idle", {flash_ready, flashCs}, 2'b11);

        check("mosi_stable_while_sck_high", n_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
